// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads words from the instruction
// cache and loads the instruction register consumed by the main decoder.
// A one-entry skid buffer absorbs a fetch that lands while the decoder
// stalls, and redirects may arrive even while a cache miss is in flight.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic [31:0] ICACHE_rdata,
    input  logic        ICACHE_stall,
    output logic [31:0] IR,
    output logic        IR_valid,
    output logic [31:0] IR_pc,
    output logic [5:0]  IR_opcode,
    output logic [5:0]  IR_func
);

    // REQ: request on pc; HOLD: skid full, waiting for the decoder;
    // KILL: draining a miss whose data must be thrown away.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [29:0] kill_addr_q, kill_addr_d;

    logic        done;
    logic        consume;
    logic [31:0] redirect_target;
    logic        unused_redirect_low;

    // The low redirect bits are dropped: fetches are always word aligned.
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];

    // Cache request and handshake terms; the request is masked during reset
    // so a stale address never reaches the cache.
    always_comb begin
        ICACHE_ren  = !rst && (state_q == REQ || state_q == KILL);
        ICACHE_addr = 30'd0;
        if (!rst) begin
            if (state_q == KILL) begin
                ICACHE_addr = kill_addr_q;
            end else begin
                ICACHE_addr = pc_q[31:2];
            end
        end
        done    = ICACHE_ren && !ICACHE_stall;
        consume = ir_valid_q && !stall;
    end

    // Decoder-facing views of the instruction register.
    always_comb begin
        IR        = ir_q;
        IR_pc     = ir_pc_q;
        IR_valid  = ir_valid_q;
        IR_opcode = ir_q[31:26];
        IR_func   = ir_q[5:0];
    end

    // Next-state logic: a redirect overrides everything, otherwise each state
    // moves fetched data into IR, the skid buffer, or discards it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        skid_d      = skid_q;
        skid_pc_d   = skid_pc_q;
        kill_addr_d = kill_addr_q;

        if (redirect_valid) begin
            ir_valid_d = 1'b0;
            pc_d       = redirect_target;
            unique case (state_q)
                REQ: begin
                    if (ICACHE_stall) begin
                        kill_addr_d = pc_q[31:2];
                        state_d     = KILL;
                    end
                end
                HOLD:    state_d = REQ;
                KILL:    state_d = KILL;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (done) begin
                        if (!ir_valid_q || !stall) begin
                            ir_d       = ICACHE_rdata;
                            ir_pc_d    = pc_q;
                            ir_valid_d = 1'b1;
                        end else begin
                            skid_d    = ICACHE_rdata;
                            skid_pc_d = pc_q;
                            state_d   = HOLD;
                        end
                        pc_d = pc_q + 32'd4;
                    end else if (consume) begin
                        ir_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ir_d       = skid_q;
                        ir_pc_d    = skid_pc_q;
                        ir_valid_d = 1'b1;
                        state_d    = REQ;
                    end
                end
                KILL: begin
                    if (done) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // State registers with synchronous reset; any in-flight response is
    // simply forgotten when reset hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            ir_pc_q     <= 32'd0;
            ir_valid_q  <= 1'b0;
            skid_q      <= 32'd0;
            skid_pc_q   <= 32'd0;
            kill_addr_q <= 30'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            skid_q      <= skid_d;
            skid_pc_q   <= skid_pc_d;
            kill_addr_q <= kill_addr_d;
        end
    end

endmodule
